// File: rtl/strip_pkg.sv
// Shared definitions for the strip allocation controller.
//   NO_STRIP       : strip ID meaning "no candidate" / rejected grant
//   H_MIN, H_MAX   : legal parcel height range (inclusive)
//   ADDR_CLAMP     : ROM address used for every height >= H_MIN + ADDR_CLAMP
//   state_e        : controller FSM states
//   height_to_addr : returns {legal, addr}
package strip_pkg;

  localparam logic [3:0]  NO_STRIP   = 4'hF;
  localparam int unsigned H_MIN      = 4;
  localparam int unsigned H_MAX      = 16;
  localparam int unsigned ADDR_CLAMP = 9;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StCheck,
    StResp
  } state_e;

  function automatic logic [4:0] height_to_addr(input logic [4:0] h);
    logic       legal;
    logic [3:0] addr;
    legal = (32'(h) >= H_MIN) && (32'(h) <= H_MAX);
    addr  = 4'h0;
    if (legal) begin
      if (32'(h) >= H_MIN + ADDR_CLAMP) addr = 4'(ADDR_CLAMP);
      else                              addr = 4'(h - 5'(H_MIN));
    end
    return {legal, addr};
  endfunction

endpackage

// File: rtl/strip_occ_table.sv
// Per-strip occupancy counters.
//   inc_valid_i/inc_id_i : take one slot (ignored if the strip is already at CAP)
//   dec_valid_i/dec_id_i : release one slot; illegal if id >= NSTRIP or count is 0
//   rd_id_i/rd_cnt_o     : three combinational count lookups (unknown IDs read 0)
//   full_mask_o          : bit i set when count[i] == CAP
//   rel_err_o            : registered one-cycle pulse after an illegal release
module strip_occ_table
  import strip_pkg::*;
#(
  parameter int unsigned CAP    = 4,
  parameter int unsigned NSTRIP = 15,
  parameter int unsigned CntW   = $clog2(CAP + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inc_valid_i,
  input  logic [3:0]            inc_id_i,
  input  logic                  dec_valid_i,
  input  logic [3:0]            dec_id_i,
  input  logic [2:0][3:0]       rd_id_i,
  output logic [2:0][CntW-1:0]  rd_cnt_o,
  output logic [NSTRIP-1:0]     full_mask_o,
  output logic                  rel_err_o
);

  logic [CntW-1:0]   cnt_q [NSTRIP];
  logic [CntW-1:0]   cnt_d [NSTRIP];
  logic [NSTRIP-1:0] inc_hit;
  logic [NSTRIP-1:0] dec_hit;
  logic              rel_err_q, rel_err_d;

  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int i = 0; i < int'(NSTRIP); i++) begin
      cnt_d[i]   = cnt_q[i];
      inc_hit[i] = inc_valid_i && (inc_id_i == 4'(i)) && (cnt_q[i] < CntW'(CAP));
      dec_hit[i] = dec_valid_i && (dec_id_i == 4'(i)) && (cnt_q[i] != '0);
      // Take and release on the same strip cancel out.
      if (inc_hit[i] && !dec_hit[i])      cnt_d[i] = cnt_q[i] + CntW'(1);
      else if (dec_hit[i] && !inc_hit[i]) cnt_d[i] = cnt_q[i] - CntW'(1);
    end
    rel_err_d = dec_valid_i && (dec_hit == '0);
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rd_cnt_o[r] = '0;
      for (int i = 0; i < int'(NSTRIP); i++) begin
        if (rd_id_i[r] == 4'(i)) rd_cnt_o[r] = cnt_q[i];
      end
    end
    for (int i = 0; i < int'(NSTRIP); i++) begin
      full_mask_o[i] = (cnt_q[i] == CntW'(CAP));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NSTRIP); i++) cnt_q[i] <= '0;
      rel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NSTRIP); i++) cnt_q[i] <= cnt_d[i];
      rel_err_q <= rel_err_d;
    end
  end

  assign rel_err_o = rel_err_q;

endmodule

// File: rtl/strip_alloc_ctrl.sv
// Strip allocation controller: maps a parcel height to a ROM address, performs one
// registered ROM read, grants the first candidate with free capacity and tracks
// occupancy through strip_occ_table.
//   req_*    : height request (accepted only in idle)
//   rsp_*    : grant/reject response, held until rsp_ready_i
//   rel_*    : slot release, accepted in any state; rel_err_o flags illegal releases
//   rom_*    : ROM enable/address out, three priority-ordered candidates back
//   full_mask_o : per-strip "at capacity" flags
module strip_alloc_ctrl
  import strip_pkg::*;
#(
  parameter int unsigned CAP    = 4,
  parameter int unsigned NSTRIP = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_height_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_ok_o,
  output logic [3:0]        rsp_id_o,
  input  logic              rel_valid_i,
  input  logic [3:0]        rel_id_i,
  output logic              rel_err_o,
  output logic              rom_en_o,
  output logic [3:0]        rom_addr_o,
  input  logic [3:0]        rom_id1_i,
  input  logic [3:0]        rom_id2_i,
  input  logic [3:0]        rom_id3_i,
  output logic [NSTRIP-1:0] full_mask_o
);

  localparam int unsigned CntW = $clog2(CAP + 1);

  state_e              state_q, state_d;
  logic [3:0]          addr_q, addr_d;
  logic                rsp_ok_q, rsp_ok_d;
  logic [3:0]          rsp_id_q, rsp_id_d;
  logic [4:0]          hta;
  logic [2:0][3:0]     cand;
  logic [2:0][CntW-1:0] cand_cnt;
  logic                hit;
  logic [3:0]          pick;
  logic                inc_valid;

  assign hta  = height_to_addr(req_height_i);
  assign cand = {rom_id3_i, rom_id2_i, rom_id1_i};

  // First candidate in priority order that is a real strip with a free slot.
  // Uses the registered count, so a same-cycle release never creates room.
  always_comb begin
    hit  = 1'b0;
    pick = NO_STRIP;
    for (int c = 0; c < 3; c++) begin
      if (!hit && (cand[c] != NO_STRIP) && (32'(cand[c]) < NSTRIP) &&
          (cand_cnt[c] < CntW'(CAP))) begin
        hit  = 1'b1;
        pick = cand[c];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rsp_ok_d  = rsp_ok_q;
    rsp_id_d  = rsp_id_q;
    inc_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          if (hta[4]) begin
            addr_d  = hta[3:0];
            state_d = StLookup;
          end else begin
            rsp_ok_d = 1'b0;
            rsp_id_d = NO_STRIP;
            state_d  = StResp;
          end
        end
      end
      StLookup: state_d = StCheck;
      StCheck: begin
        inc_valid = hit;
        rsp_ok_d  = hit;
        rsp_id_d  = pick;
        state_d   = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rsp_ok_q <= 1'b0;
      rsp_id_q <= NO_STRIP;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rsp_ok_q <= rsp_ok_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  // Decoded from the state register so the ROM enable drops with async reset.
  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rom_en_o    = (state_q == StLookup);
  assign rom_addr_o  = (state_q == StLookup) ? addr_q : 4'h0;
  assign rsp_ok_o    = rsp_ok_q;
  assign rsp_id_o    = rsp_id_q;

  strip_occ_table #(
    .CAP    (CAP),
    .NSTRIP (NSTRIP),
    .CntW   (CntW)
  ) u_occ (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_valid_i (inc_valid),
    .inc_id_i    (pick),
    .dec_valid_i (rel_valid_i),
    .dec_id_i    (rel_id_i),
    .rd_id_i     (cand),
    .rd_cnt_o    (cand_cnt),
    .full_mask_o (full_mask_o),
    .rel_err_o   (rel_err_o)
  );

endmodule

// File: tb/tb_strip_alloc_ctrl.sv
// Directed bench for strip_alloc_ctrl with a behavioural strip-ID ROM (CAP=4).
module tb_strip_alloc_ctrl;

  localparam logic [3:0] NS = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_height = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_ok;
  logic [3:0]  rsp_id;
  logic        rel_valid = 1'b0;
  logic [3:0]  rel_id = '0;
  logic        rel_err, rom_en;
  logic [3:0]  rom_addr;
  logic [3:0]  rom_id1 = NS, rom_id2 = NS, rom_id3 = NS;
  logic [14:0] full_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  strip_alloc_ctrl #(.CAP(4), .NSTRIP(15)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_height_i (req_height),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_ok_o     (rsp_ok),
    .rsp_id_o     (rsp_id),
    .rel_valid_i  (rel_valid),
    .rel_id_i     (rel_id),
    .rel_err_o    (rel_err),
    .rom_en_o     (rom_en),
    .rom_addr_o   (rom_addr),
    .rom_id1_i    (rom_id1),
    .rom_id2_i    (rom_id2),
    .rom_id3_i    (rom_id3),
    .full_mask_o  (full_mask)
  );

  function automatic logic [11:0] rom_word(input logic [3:0] a);
    case (a)
      4'd0:    return {4'd9, 4'd7, NS};
      4'd1:    return {4'd6, 4'd8, 4'd10};
      4'd2:    return {4'd11, 4'd12, 4'd13};
      4'd3:    return {4'd14, NS, NS};
      4'd4:    return {4'd0, 4'd1, 4'd2};
      4'd5:    return {4'd1, 4'd2, 4'd3};
      4'd6:    return {4'd2, 4'd3, 4'd4};
      4'd7:    return {4'd5, 4'd6, 4'd7};
      4'd8:    return {4'd8, 4'd10, 4'd11};
      4'd9:    return {4'd3, 4'd4, 4'd5};
      default: return {NS, NS, NS};
    endcase
  endfunction

  // Registered ROM: data valid the cycle after rom_en.
  always @(posedge clk) begin
    if (rom_en) {rom_id1, rom_id2, rom_id3} <= rom_word(rom_addr);
  end

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; rel_valid = 1'b0;
    rel_id = '0; req_height = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full request/response; optionally releases rid while the FSM is in CHECK.
  task automatic do_req(input logic [4:0] h, input bit rel_chk, input logic [3:0] rid,
                        output bit rom_seen, output logic [3:0] addr_seen, output int lat,
                        output logic ok, output logic [3:0] id);
    rom_seen = 1'b0; addr_seen = '0; lat = -1;
    req_valid = 1'b1; req_height = h;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0; rel_valid = 1'b0;
      if (rom_en) begin rom_seen = 1'b1; addr_seen = rom_addr; end
      if (rsp_valid) lat = k;
      else if (k == 2 && rel_chk) begin rel_valid = 1'b1; rel_id = rid; end
    end
    ok = rsp_ok; id = rsp_id;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_rel(input logic [3:0] rid, output logic err_now, output logic err_after);
    rel_valid = 1'b1; rel_id = rid;
    @(negedge clk);
    rel_valid = 1'b0;
    err_now = rel_err;
    @(negedge clk);
    err_after = rel_err;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_ok, rsp_id} !== {1'b1, 1'b0, 1'b0, NS}) begin
      n_bad++;
      $display("FAIL reset_rsp: got rdy/val/ok/id=%b/%b/%b/%h want 1/0/0/f",
               req_ready, rsp_valid, rsp_ok, rsp_id);
    end
    n_cmp++;
    if ({rom_en, rom_addr} !== 5'h00) begin
      n_bad++; $display("FAIL reset_rom: got en=%b addr=%0d want 0/0", rom_en, rom_addr);
    end
    n_cmp++;
    if ({rel_err, full_mask} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_flags: got err=%b mask=%h want 0/0000", rel_err, full_mask);
    end
  endtask

  task automatic test_basic();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id;
    apply_reset();
    do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
    n_cmp++;
    if ({rs, ad} !== {1'b1, 4'd4}) begin
      n_bad++; $display("FAIL basic_rom: got en=%b addr=%0d want 1/4", rs, ad);
    end
    n_cmp++;
    if (lat !== 3) begin n_bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_cmp++;
    if ({ok, id} !== {1'b1, 4'd0}) begin
      n_bad++; $display("FAIL basic_grant: got ok=%b id=%h want 1/0", ok, id);
    end
  endtask

  task automatic test_fill();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id;
    logic [3:0] exp_id [5] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
      n_cmp++;
      if ({ok, id} !== {1'b1, exp_id[k]}) begin
        n_bad++; $display("FAIL fill_grant%0d: got ok=%b id=%h want 1/%h", k, ok, id, exp_id[k]);
      end
      if (k == 3 || k == 4) begin
        n_cmp++;
        if (full_mask !== 15'h0001) begin
          n_bad++; $display("FAIL fill_mask%0d: got %h want 0001", k, full_mask);
        end
      end
    end
  endtask

  task automatic test_illegal();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id;
    logic [4:0] hs [4] = '{5'd3, 5'd17, 5'd0, 5'd31};
    for (int k = 0; k < 4; k++) begin
      do_req(hs[k], 1'b0, 4'd0, rs, ad, lat, ok, id);
      n_cmp++;
      if ({rs, lat, ok, id} !== {1'b0, 32'sd1, 1'b0, NS}) begin
        n_bad++;
        $display("FAIL illegal_h%0d: got rom=%b lat=%0d ok=%b id=%h want 0/1/0/f",
                 hs[k], rs, lat, ok, id);
      end
    end
  endtask

  task automatic test_addr_map();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id; logic [3:0] ea;
    apply_reset();
    for (int h = 4; h <= 16; h++) begin
      ea = (h <= 12) ? 4'(h - 4) : 4'd9;
      do_req(5'(h), 1'b0, 4'd0, rs, ad, lat, ok, id);
      n_cmp++;
      if ({rs, ad} !== {1'b1, ea}) begin
        n_bad++; $display("FAIL addr_map_h%0d: got en=%b addr=%0d want 1/%0d", h, rs, ad, ea);
      end
    end
  endtask

  task automatic test_full_reject();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id; logic [3:0] eid;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      eid = (k < 4) ? 4'd9 : (k < 8) ? 4'd7 : NS;
      do_req(5'd4, 1'b0, 4'd0, rs, ad, lat, ok, id);
      n_cmp++;
      if ({ok, id} !== {(k < 8), eid}) begin
        n_bad++; $display("FAIL full_grant%0d: got ok=%b id=%h want %b/%h", k, ok, id, k < 8, eid);
      end
    end
    n_cmp++;
    if (full_mask !== 15'h0280) begin
      n_bad++; $display("FAIL full_mask: got %h want 0280", full_mask);
    end
  endtask

  // Continues from the state left by test_full_reject (strips 7 and 9 full).
  task automatic test_release();
    logic e0, e1;
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id;
    for (int k = 0; k < 2; k++) begin
      pulse_rel(4'd5, e0, e1);
      n_cmp++;
      if ({e0, e1} !== 2'b10) begin
        n_bad++; $display("FAIL rel_empty%0d: got err=%b then %b want 1 then 0", k, e0, e1);
      end
    end
    pulse_rel(NS, e0, e1);
    n_cmp++;
    if ({e0, e1} !== 2'b10) begin
      n_bad++; $display("FAIL rel_bad_id: got err=%b then %b want 1 then 0", e0, e1);
    end
    pulse_rel(4'd9, e0, e1);
    n_cmp++;
    if ({e0, full_mask} !== {1'b0, 15'h0080}) begin
      n_bad++; $display("FAIL rel_legal: got err=%b mask=%h want 0/0080", e0, full_mask);
    end
    do_req(5'd4, 1'b0, 4'd0, rs, ad, lat, ok, id);
    n_cmp++;
    if ({ok, id, full_mask} !== {1'b1, 4'd9, 15'h0280}) begin
      n_bad++; $display("FAIL rel_regrant: got ok=%b id=%h mask=%h want 1/9/0280", ok, id, full_mask);
    end
  endtask

  task automatic test_same_cycle();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id;
    logic [3:0] eid;
    apply_reset();
    do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
    do_req(5'd8, 1'b1, 4'd0, rs, ad, lat, ok, id);
    n_cmp++;
    if ({ok, id, rel_err} !== {1'b1, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL same_grant: got ok=%b id=%h err=%b want 1/0/0", ok, id, rel_err);
    end
    // Count of strip 0 should still be 1: three more grants fill it, then strip 1.
    for (int k = 0; k < 4; k++) begin
      eid = (k < 3) ? 4'd0 : 4'd1;
      do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
      n_cmp++;
      if ({ok, id} !== {1'b1, eid}) begin
        n_bad++; $display("FAIL same_after%0d: got ok=%b id=%h want 1/%h", k, ok, id, eid);
      end
    end
  endtask

  task automatic test_stall();
    int waited;
    apply_reset();
    req_valid = 1'b1; req_height = 5'd8;
    waited = 0;
    do begin
      @(negedge clk); req_valid = 1'b0; waited++;
    end while (!rsp_valid && waited < 8);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_ok, rsp_id} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
        n_bad++;
        $display("FAIL stall_cyc%0d: got val/rdy/ok/id=%b/%b/%b/%h want 1/0/1/0",
                 i, rsp_valid, req_ready, rsp_ok, rsp_id);
      end
      if (i == 3 || i == 5) begin
        n_cmp++;
        if (rel_err !== (i == 5)) begin
          n_bad++; $display("FAIL stall_relerr%0d: got %b want %b", i, rel_err, i == 5);
        end
      end
      rel_valid = (i == 2 || i == 4); rel_id = 4'd0;
      @(negedge clk);
    end
    rel_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL stall_exit: got rdy=%b val=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bit rs; logic [3:0] ad; int lat; logic ok; logic [3:0] id; bit seen;
    apply_reset();
    repeat (4) do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
    n_cmp++;
    if (full_mask !== 15'h0001) begin
      n_bad++; $display("FAIL mid_prefill: got %h want 0001", full_mask);
    end
    req_valid = 1'b1; req_height = 5'd8;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if ({rom_en, rom_addr} !== {1'b1, 4'd4}) begin
      n_bad++; $display("FAIL mid_lookup: got en=%b addr=%0d want 1/4", rom_en, rom_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rom_en, rom_addr, rsp_valid, rsp_ok, rsp_id, req_ready, full_mask} !==
        {1'b0, 4'd0, 1'b0, 1'b0, NS, 1'b1, 15'h0000}) begin
      n_bad++;
      $display("FAIL mid_async: got en=%b addr=%0d val=%b ok=%b id=%h rdy=%b mask=%h",
               rom_en, rom_addr, rsp_valid, rsp_ok, rsp_id, req_ready, full_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || rom_en) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_resp: got activity=1 want 0"); end
    do_req(5'd8, 1'b0, 4'd0, rs, ad, lat, ok, id);
    n_cmp++;
    if ({ok, id, full_mask} !== {1'b1, 4'd0, 15'h0000}) begin
      n_bad++; $display("FAIL mid_cleared: got ok=%b id=%h mask=%h want 1/0/0000", ok, id, full_mask);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_illegal();
    test_addr_map();
    test_full_reject();
    test_release();
    test_same_cycle();
    test_stall();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/strip_alloc_ctrl.md
# strip_alloc_ctrl

Allocation controller for the strip-ID ROM. It accepts a parcel height, maps the height to a ROM address, and sequences one registered ROM read to get three candidate strips in priority order. It grants the highest-priority candidate with free capacity and tracks per-strip occupancy, which is decremented by release events. It sits between the request front end and the ROM, and is the only master of the ROM's enable and address pins.

## Interface
Parameters:
- CAP, 4: slot capacity of every strip (1..15).
- NSTRIP, 15: number of real strips; IDs 0..14. ID 4'hF means "no candidate".

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  allocation request.
- req_ready  out  1  high in IDLE only.
- req_height  in  5  parcel height, legal range 4..16.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response accept.
- rsp_ok  out  1  1 means granted, 0 means rejected.
- rsp_id  out  4  granted strip; 4'hF when rejected.
- rel_valid  in  1  release one slot of rel_id; accepted in any state.
- rel_id  in  4  strip being released.
- rel_err  out  1  one-cycle pulse: illegal release.
- rom_en  out  1  ROM read enable.
- rom_addr  out  4  ROM address 0..9.
- rom_id1/rom_id2/rom_id3  in  4 each  ROM candidates; rom_id1 has the highest priority; valid the cycle after rom_en.
- full_mask  out  15  bit i is set when count[i] == CAP.

## Operation
- Height to address mapping:
  - h in 4..12 maps to h-4.
  - h in 13..16 maps to 9.
  - h < 4 or h > 16 is illegal.
- The FSM has states IDLE, LOOKUP, CHECK and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the height.
  - If the height is legal, go to LOOKUP.
  - If the height is illegal, go to RESP with rsp_ok=0 and rsp_id=F. No ROM access is made.
- LOOKUP:
  - rom_en=1 and rom_addr=mapped address for exactly this one cycle.
  - Go to CHECK.
- CHECK:
  - Scan rom_id1, then rom_id2, then rom_id3.
  - Pick the first candidate that is not F, is below NSTRIP, and has registered count < CAP.
  - On a hit: increment its count, rsp_ok=1, rsp_id=that candidate.
  - On a miss: rsp_ok=0, rsp_id=F.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_ok and rsp_id stay stable.
  - On rsp_ready, go to IDLE.
- Release:
  - A release is legal when rel_id < NSTRIP and count > 0; the count is then decremented.
  - Otherwise the count is unchanged and rel_err pulses the next cycle.
- Simultaneous increment and release on the same strip in CHECK leaves the count unchanged (net 0).
- Capacity checks in CHECK use the registered count, before this cycle's release is applied. This is conservative and must not overflow.
- Counters are $clog2(CAP+1) bits wide and saturate by construction: they never exceed CAP and never go below 0.

## Timing
- Reset values:
  - state=IDLE.
  - All counts 0.
  - rsp_valid=0, rsp_ok=0, rsp_id=F.
  - rom_en=0, rom_addr=0.
  - rel_err=0, full_mask=0.
  - req_ready=1 once rst_n is deasserted.
- Legal request accepted at edge T:
  - LOOKUP runs during cycle T+1.
  - ROM data is valid during T+2 (CHECK).
  - rsp_valid is high from T+3.
- Illegal-height request accepted at T: rsp_valid is high from T+1.
- Back-to-back throughput is one request per 4 cycles minimum, when rsp_ready is held high.
- rsp_ready=1 in the first RESP cycle returns the FSM to IDLE the next cycle.
- rsp_ready low keeps the FSM stalled in RESP with outputs frozen. Releases still update counts during the stall.
- Asserting rst_n mid-transaction aborts it immediately: no response, counts cleared, rom_en drops asynchronously.

## Structure
- Package strip_pkg holds:
  - NO_STRIP=4'hF, H_MIN=4, H_MAX=16, ADDR_CLAMP=9.
  - The state enum.
  - Function height_to_addr(h) returning {legal, addr}.
- Sub-module strip_occ_table holds:
  - The counter array.
  - An inc port (valid, id) and a dec port (valid, id) with the same-id net-zero rule.
  - count read by three ids combinationally.
  - The full_mask output and the rel_err generation.
- The FSM and the priority pick live in the top level.

## Test plan
All scenarios run with the strip-ID ROM attached and CAP=4.
- Height 8: rom_addr=4 in LOOKUP (ROM returns 0,1,2), then rsp_ok=1 and rsp_id=0 at T+3.
- Five height-8 requests: grants 0,0,0,0,1. full_mask[0]=1 after the fourth grant.
- Height 3 or height 17: rom_en never asserts; rsp_ok=0 and rsp_id=F at T+1.
- Height 4 (ROM returns 9,7,F) with strips 9 and 7 full: rsp_ok=0, rsp_id=F. Heights 13..16 all drive rom_addr=9.
- rel_valid with rel_id=5 while count[5]=0: rel_err pulses and the count stays 0. rel_id=F: rel_err pulses. A release of strip 0 in CHECK while strip 0 is granted: count unchanged.
- Hold rsp_ready low for 10 cycles: response stable and req_ready=0 throughout. Drop rst_n during LOOKUP: all outputs at reset values and counts 0.
